// File: rtl/vga_csr_pkg.sv
// Shared constants for the VGA CSR register file: word addresses, CTRL/STATUS bit
// positions and HCFG/VCFG field layout.
package vga_csr_pkg;

  localparam logic [7:0] ADDR_CTRL      = 8'h00;
  localparam logic [7:0] ADDR_STATUS    = 8'h01;
  localparam logic [7:0] ADDR_FB_BASE   = 8'h02;
  localparam logic [7:0] ADDR_HCFG      = 8'h03;
  localparam logic [7:0] ADDR_VCFG      = 8'h04;
  localparam logic [7:0] ADDR_FRAME_CNT = 8'h05;
  localparam logic [7:0] ADDR_SCRATCH   = 8'h06;
  localparam logic [7:0] ADDR_ID        = 8'h07;

  localparam int unsigned CTRL_ENABLE    = 0;
  localparam int unsigned CTRL_IRQ_EN    = 1;
  localparam int unsigned CTRL_TEST_PAT  = 2;
  localparam int unsigned CTRL_W         = 3;

  localparam int unsigned STATUS_VSYNC   = 0;
  localparam int unsigned STATUS_VBLANK  = 1;

  localparam int unsigned CFG_FIELD_W    = 12;
  localparam int unsigned CFG_ACTIVE_LSB = 0;
  localparam int unsigned CFG_TOTAL_LSB  = 16;

  // Internal timing storage is {total, active}; this restores the bus layout.
  function automatic logic [31:0] pack_cfg(input logic [2*CFG_FIELD_W-1:0] cfg);
    logic [31:0] w;
    w = '0;
    w[CFG_ACTIVE_LSB +: CFG_FIELD_W] = cfg[CFG_FIELD_W-1:0];
    w[CFG_TOTAL_LSB  +: CFG_FIELD_W] = cfg[2*CFG_FIELD_W-1:CFG_FIELD_W];
    return w;
  endfunction

endpackage

// File: rtl/vga_csr_regs_if.sv
// CSR bus between an initiator (sim driver / HPS bridge) and the VGA register file.
interface vga_csr_regs_if;
  logic [7:0]  csr_address;
  logic        csr_write;
  logic [31:0] csr_wr_data;
  logic        csr_read;
  logic [31:0] csr_rd_data;

  modport master (
    output csr_address,
    output csr_write,
    output csr_wr_data,
    output csr_read,
    input  csr_rd_data
  );

  modport slave (
    input  csr_address,
    input  csr_write,
    input  csr_wr_data,
    input  csr_read,
    output csr_rd_data
  );
endinterface

// File: rtl/vga_shadow_reg.sv
// Pending/active register pair: software writes the pending copy, the active copy
// picks it up only when copy_i is asserted.
module vga_shadow_reg #(
  parameter int unsigned      Width    = 32,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             copy_i,
  output logic [Width-1:0] pend_o,
  output logic [Width-1:0] active_o
);

  logic [Width-1:0] pend_d, pend_q;
  logic [Width-1:0] active_d, active_q;

  // A copy coincident with a write transfers the old pending value.
  always_comb begin
    pend_d   = we_i   ? wdata_i : pend_q;
    active_d = copy_i ? pend_q  : active_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q   <= ResetVal;
      active_q <= ResetVal;
    end else begin
      pend_q   <= pend_d;
      active_q <= active_d;
    end
  end

  assign pend_o   = pend_q;
  assign active_o = active_q;

endmodule

// File: rtl/vga_csr_regs.sv
// VGA controller CSR block: control, shadowed framebuffer/timing config, frame counter
// and vsync interrupt behind a single-cycle 8-bit-address register bus.
module vga_csr_regs
  import vga_csr_pkg::*;
#(
  parameter logic [31:0] ID_VALUE     = 32'h5647_4131,
  parameter int unsigned DEF_H_ACTIVE = 640,
  parameter int unsigned DEF_H_TOTAL  = 800,
  parameter int unsigned DEF_V_ACTIVE = 480,
  parameter int unsigned DEF_V_TOTAL  = 525
) (
  input  logic                clk,
  input  logic                reset_n,
  vga_csr_regs_if.slave       csr,
  input  logic                frame_start,
  input  logic                vblank,
  output logic                enable,
  output logic                test_pattern,
  output logic [31:0]         fb_base,
  output logic [11:0]         h_active,
  output logic [11:0]         h_total,
  output logic [11:0]         v_active,
  output logic [11:0]         v_total,
  output logic                irq
);

  localparam int unsigned CfgW = 2 * CFG_FIELD_W;
  localparam logic [CfgW-1:0] HCfgReset = {12'(DEF_H_TOTAL), 12'(DEF_H_ACTIVE)};
  localparam logic [CfgW-1:0] VCfgReset = {12'(DEF_V_TOTAL), 12'(DEF_V_ACTIVE)};

  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [31:0]       scratch_d, scratch_q;
  logic [31:0]       frame_cnt_d, frame_cnt_q;
  logic              vsync_pend_d, vsync_pend_q;
  logic              irq_d, irq_q;
  logic [31:0]       rd_data_d, rd_data_q;
  logic [31:0]       rd_mux;

  logic we_ctrl, we_status, we_fb, we_hcfg, we_vcfg, we_cnt, we_scratch;
  logic frame_tick, copy_en;
  logic [CfgW-1:0] cfg_wdata;
  logic [31:0]     fb_pend;
  logic [CfgW-1:0] hcfg_pend, hcfg_act, vcfg_pend, vcfg_act;

  always_comb begin
    we_ctrl    = csr.csr_write && (csr.csr_address == ADDR_CTRL);
    we_status  = csr.csr_write && (csr.csr_address == ADDR_STATUS);
    we_fb      = csr.csr_write && (csr.csr_address == ADDR_FB_BASE);
    we_hcfg    = csr.csr_write && (csr.csr_address == ADDR_HCFG);
    we_vcfg    = csr.csr_write && (csr.csr_address == ADDR_VCFG);
    we_cnt     = csr.csr_write && (csr.csr_address == ADDR_FRAME_CNT);
    we_scratch = csr.csr_write && (csr.csr_address == ADDR_SCRATCH);
    frame_tick = frame_start && ctrl_q[CTRL_ENABLE];
    // Disabled: shadows are transparent (one cycle late); enabled: frame-aligned.
    copy_en    = frame_start || !ctrl_q[CTRL_ENABLE];
    cfg_wdata  = {csr.csr_wr_data[CFG_TOTAL_LSB +: CFG_FIELD_W],
                  csr.csr_wr_data[CFG_ACTIVE_LSB +: CFG_FIELD_W]};
  end

  vga_shadow_reg #(.Width(32), .ResetVal(32'h0)) u_fb_base (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .we_i     (we_fb),
    .wdata_i  (csr.csr_wr_data),
    .copy_i   (copy_en),
    .pend_o   (fb_pend),
    .active_o (fb_base)
  );

  vga_shadow_reg #(.Width(CfgW), .ResetVal(HCfgReset)) u_hcfg (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .we_i     (we_hcfg),
    .wdata_i  (cfg_wdata),
    .copy_i   (copy_en),
    .pend_o   (hcfg_pend),
    .active_o (hcfg_act)
  );

  vga_shadow_reg #(.Width(CfgW), .ResetVal(VCfgReset)) u_vcfg (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .we_i     (we_vcfg),
    .wdata_i  (cfg_wdata),
    .copy_i   (copy_en),
    .pend_o   (vcfg_pend),
    .active_o (vcfg_act)
  );

  always_comb begin
    ctrl_d    = we_ctrl ? csr.csr_wr_data[CTRL_W-1:0] : ctrl_q;
    scratch_d = we_scratch ? csr.csr_wr_data : scratch_q;

    // A clearing write beats a coincident increment.
    frame_cnt_d = frame_cnt_q;
    if (we_cnt) begin
      frame_cnt_d = '0;
    end else if (frame_tick) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
    end

    // Set beats a coincident write-1-to-clear.
    vsync_pend_d = frame_tick ||
                   (vsync_pend_q && !(we_status && csr.csr_wr_data[STATUS_VSYNC]));
    irq_d        = vsync_pend_q && ctrl_q[CTRL_IRQ_EN];
  end

  always_comb begin
    rd_mux = '0;
    case (csr.csr_address)
      ADDR_CTRL:      rd_mux[CTRL_W-1:0] = ctrl_q;
      ADDR_STATUS: begin
        rd_mux[STATUS_VSYNC]  = vsync_pend_q;
        rd_mux[STATUS_VBLANK] = vblank;
      end
      ADDR_FB_BASE:   rd_mux = fb_pend;
      ADDR_HCFG:      rd_mux = pack_cfg(hcfg_pend);
      ADDR_VCFG:      rd_mux = pack_cfg(vcfg_pend);
      ADDR_FRAME_CNT: rd_mux = frame_cnt_q;
      ADDR_SCRATCH:   rd_mux = scratch_q;
      ADDR_ID:        rd_mux = ID_VALUE;
      default:        rd_mux = '0;
    endcase
    rd_data_d = csr.csr_read ? rd_mux : rd_data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q       <= '0;
      scratch_q    <= '0;
      frame_cnt_q  <= '0;
      vsync_pend_q <= 1'b0;
      irq_q        <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      scratch_q    <= scratch_d;
      frame_cnt_q  <= frame_cnt_d;
      vsync_pend_q <= vsync_pend_d;
      irq_q        <= irq_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign csr.csr_rd_data = rd_data_q;
  assign enable          = ctrl_q[CTRL_ENABLE];
  assign test_pattern    = ctrl_q[CTRL_TEST_PAT];
  assign irq             = irq_q;
  assign h_active        = hcfg_act[CFG_FIELD_W-1:0];
  assign h_total         = hcfg_act[CfgW-1:CFG_FIELD_W];
  assign v_active        = vcfg_act[CFG_FIELD_W-1:0];
  assign v_total         = vcfg_act[CfgW-1:CFG_FIELD_W];

endmodule

// File: tb/tb_vga_csr_regs.sv
// Directed bench for vga_csr_regs: read expectations go through a scoreboard queue and
// are popped when the registered read data appears.
module tb_vga_csr_regs;

  logic        clk;
  logic        reset_n;
  logic        frame_start;
  logic        vblank;
  logic        enable;
  logic        test_pattern;
  logic [31:0] fb_base;
  logic [11:0] h_active, h_total, v_active, v_total;
  logic        irq;

  int n_checks;
  int n_fails;
  logic [31:0] exp_q[$];

  vga_csr_regs_if bus ();

  vga_csr_regs dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .csr          (bus),
    .frame_start  (frame_start),
    .vblank       (vblank),
    .enable       (enable),
    .test_pattern (test_pattern),
    .fb_base      (fb_base),
    .h_active     (h_active),
    .h_total      (h_total),
    .v_active     (v_active),
    .v_total      (v_total),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Single bus cycle; optional write, read and frame_start all in the same clock.
  task automatic bus_cycle(input logic wr, input logic rd, input logic fs,
                           input logic [7:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.csr_address = addr;
    bus.csr_write   = wr;
    bus.csr_read    = rd;
    bus.csr_wr_data = data;
    frame_start     = fs;
    @(posedge clk);
    #1;
    bus.csr_write   = 1'b0;
    bus.csr_read    = 1'b0;
    frame_start     = 1'b0;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    bus_cycle(1'b1, 1'b0, 1'b0, addr, data);
  endtask

  task automatic pulse();
    bus_cycle(1'b0, 1'b0, 1'b1, 8'h00, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic pop_chk(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, bus.csr_rd_data, e);
    end
  endtask

  task automatic rd(input logic [7:0] addr, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    bus_cycle(1'b0, 1'b1, 1'b0, addr, 32'h0);
    pop_chk(tag);
  endtask

  task automatic rdwr(input logic [7:0] addr, input logic [31:0] data,
                      input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    bus_cycle(1'b1, 1'b1, 1'b0, addr, data);
    pop_chk(tag);
  endtask

  initial begin
    n_checks        = 0;
    n_fails         = 0;
    reset_n         = 1'b0;
    frame_start     = 1'b0;
    vblank          = 1'b0;
    bus.csr_address = 8'h00;
    bus.csr_write   = 1'b0;
    bus.csr_wr_data = 32'h0;
    bus.csr_read    = 1'b0;

    // Reset state
    idle(3);
    chk("rst_rd_data", bus.csr_rd_data, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_enable", {31'h0, enable}, 32'h0);
    chk("rst_h_active", {20'h0, h_active}, 32'd640);
    chk("rst_v_total", {20'h0, v_total}, 32'd525);
    @(negedge clk);
    reset_n = 1'b1;

    // 1. ID and default timing
    rd(8'h07, 32'h5647_4131, "id");
    rd(8'h03, 32'h0320_0280, "hcfg_def");
    rd(8'h04, 32'h020D_01E0, "vcfg_def");
    chk("irq_idle", {31'h0, irq}, 32'h0);

    // 2. Shadowing: transparent while disabled, frame-aligned while enabled
    wr(8'h02, 32'h1000_0000);
    chk("fb_before_copy", fb_base, 32'h0);
    idle(1);
    chk("fb_follow", fb_base, 32'h1000_0000);
    wr(8'h00, 32'h1);
    wr(8'h02, 32'h2000_0000);
    idle(3);
    chk("fb_held", fb_base, 32'h1000_0000);
    rd(8'h02, 32'h2000_0000, "fb_pend_rd");
    pulse();
    chk("fb_copied", fb_base, 32'h2000_0000);

    // 3. Frame counter, vsync_pend and irq
    wr(8'h05, 32'h0);
    wr(8'h01, 32'h1);
    wr(8'h00, 32'h3);
    idle(2);
    chk("irq_no_pend", {31'h0, irq}, 32'h0);
    pulse();
    pulse();
    pulse();
    idle(1);
    rd(8'h05, 32'd3, "frame_cnt3");
    vblank = 1'b1;
    rd(8'h01, 32'h3, "status_pend_vblank");
    vblank = 1'b0;
    chk("irq_set", {31'h0, irq}, 32'h1);
    wr(8'h01, 32'h1);
    chk("irq_lag", {31'h0, irq}, 32'h1);
    idle(1);
    chk("irq_clr", {31'h0, irq}, 32'h0);
    bus_cycle(1'b1, 1'b0, 1'b1, 8'h01, 32'h1);
    rd(8'h01, 32'h1, "w1c_vs_set");

    // 4. Frame counter clear and wrap
    wr(8'h05, 32'hABCD_1234);
    rd(8'h05, 32'h0, "cnt_wclr");
    pulse();
    bus_cycle(1'b1, 1'b0, 1'b1, 8'h05, 32'h5);
    rd(8'h05, 32'h0, "cnt_clr_vs_fs");
    @(negedge clk);
    force dut.frame_cnt_q = 32'hFFFF_FFFF;
    rd(8'h05, 32'hFFFF_FFFF, "cnt_forced");
    @(negedge clk);
    release dut.frame_cnt_q;
    pulse();
    rd(8'h05, 32'h0, "cnt_wrap");

    // 5. Scratch, unmapped address, read-during-write
    wr(8'h06, 32'hDEAD_BEEF);
    rd(8'h06, 32'hDEAD_BEEF, "scratch");
    rd(8'h3F, 32'h0, "unmapped");
    wr(8'h3F, 32'hFFFF_FFFF);
    rdwr(8'h06, 32'h1234_5678, 32'hDEAD_BEEF, "rdwr_old");
    rd(8'h06, 32'h1234_5678, "rdwr_new");
    wr(8'h00, 32'hFFFF_FFFF);
    rd(8'h00, 32'h7, "ctrl_mask");

    // 6. Asynchronous reset mid-operation
    wr(8'h00, 32'h7);
    pulse();
    idle(2);
    rd(8'h06, 32'h1234_5678, "pre_rst_rd");
    chk("pre_rst_irq", {31'h0, irq}, 32'h1);
    chk("pre_rst_tp", {31'h0, test_pattern}, 32'h1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_rd_data", bus.csr_rd_data, 32'h0);
    chk("arst_irq", {31'h0, irq}, 32'h0);
    chk("arst_enable", {31'h0, enable}, 32'h0);
    chk("arst_tp", {31'h0, test_pattern}, 32'h0);
    chk("arst_fb", fb_base, 32'h0);
    chk("arst_h_active", {20'h0, h_active}, 32'd640);
    chk("arst_h_total", {20'h0, h_total}, 32'd800);
    chk("arst_v_active", {20'h0, v_active}, 32'd480);
    chk("arst_v_total", {20'h0, v_total}, 32'd525);
    @(negedge clk);
    reset_n = 1'b1;
    rd(8'h00, 32'h0, "post_rst_ctrl");
    rd(8'h06, 32'h0, "post_rst_scratch");
    rd(8'h05, 32'h0, "post_rst_cnt");
    rd(8'h01, 32'h0, "post_rst_status");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
